// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX line encoder.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_STUFF   = 3'd2,
        ST_EOP_SE0 = 3'd3,
        ST_EOP_J   = 3'd4
    } tx_state_e;

    // Line pair encoded as {dp, dm}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [2:0] STUFF_LIMIT = 3'd6;

    function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_tx_encoder_timer.sv
// Rollover counter: counts 0..PERIOD-1 while enabled, pulses rollover_o on the wrapping cycle.
module tx_bit_timer #(
    parameter int unsigned PERIOD = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en_i,
    input  logic clr_i,
    output logic rollover_o
);

    localparam int unsigned W = $clog2(PERIOD);
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rollover_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/usb_tx_encoder.sv
// USB TX line stage: LSB-first serialiser with bit stuffing, NRZI and EOP signalling.
//   state      | meaning
//   ST_IDLE    | line parked, waiting for a load or EOP request
//   ST_SHIFT   | sending data bit idx_q of the loaded byte
//   ST_STUFF   | sending a stuffed 0 after six consecutive ones
//   ST_EOP_SE0 | both lines low for two bit periods
//   ST_EOP_J   | line at J for one bit period, then idle
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load_enable,
    input  logic [7:0] parallel_in,
    input  logic       enable_timer,
    input  logic       eop_flag,
    output logic       byte_sent,
    output logic       dp_out,
    output logic       dm_out,
    output logic       eop_active
);

    tx_state_e  state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] ones_q, ones_d;
    logic       start_q, start_d;
    logic [1:0] line_q, line_d;
    logic       sent_q, sent_d;
    logic       half_q, half_d;

    logic       tmr_en, tmr_clr, tick;
    logic       go_eop, go_load;

    assign go_eop  = eop_flag && (state_q == ST_IDLE || state_q == ST_SHIFT || state_q == ST_STUFF);
    assign go_load = load_enable && !go_eop && (state_q == ST_IDLE || state_q == ST_SHIFT);
    assign tmr_en  = (state_q == ST_EOP_SE0) || (state_q == ST_EOP_J)
                   || (enable_timer && (state_q == ST_SHIFT || state_q == ST_STUFF));

    tx_bit_timer #(.PERIOD(CLKS_PER_BIT)) u_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .en_i       (tmr_en),
        .clr_i      (tmr_clr),
        .rollover_o (tick)
    );

    // start_q marks the first cycle of a bit; the line and ones count update there.
    // CLKS_PER_BIT >= 2 keeps a bit start and a boundary from landing on the same cycle.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        ones_d  = ones_q;
        start_d = start_q;
        line_d  = line_q;
        sent_d  = 1'b0;
        half_d  = half_q;
        tmr_clr = 1'b0;

        if (go_eop) begin
            state_d = ST_EOP_SE0;
            line_d  = LINE_SE0;
            start_d = 1'b0;
            half_d  = 1'b0;
            tmr_clr = 1'b1;
        end else if (go_load) begin
            state_d = ST_SHIFT;
            shreg_d = parallel_in;
            idx_d   = 3'd0;
            start_d = 1'b1;
            tmr_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_SHIFT: begin
                    if (start_q) begin
                        start_d = 1'b0;
                        if (shreg_q[idx_q]) begin
                            ones_d = (ones_q == 3'd7) ? ones_q : ones_q + 3'd1;
                        end else begin
                            ones_d = 3'd0;
                            line_d = nrzi_toggle(line_q);
                        end
                    end
                    if (tick) begin
                        if (ones_q >= STUFF_LIMIT) begin
                            state_d = ST_STUFF;
                            start_d = 1'b1;
                        end else if (idx_q != 3'd7) begin
                            idx_d   = idx_q + 3'd1;
                            start_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            sent_d  = 1'b1;
                        end
                    end
                end
                ST_STUFF: begin
                    if (start_q) begin
                        start_d = 1'b0;
                        ones_d  = 3'd0;
                        line_d  = nrzi_toggle(line_q);
                    end
                    if (tick) begin
                        if (idx_q == 3'd7) begin
                            state_d = ST_IDLE;
                            sent_d  = 1'b1;
                        end else begin
                            state_d = ST_SHIFT;
                            idx_d   = idx_q + 3'd1;
                            start_d = 1'b1;
                        end
                    end
                end
                ST_EOP_SE0: begin
                    if (tick) begin
                        if (half_q) begin
                            state_d = ST_EOP_J;
                            half_d  = 1'b0;
                            line_d  = LINE_J;
                        end else begin
                            half_d = 1'b1;
                        end
                    end
                end
                ST_EOP_J: begin
                    if (tick) begin
                        state_d = ST_IDLE;
                        ones_d  = 3'd0;
                        line_d  = LINE_J;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            shreg_q <= 8'h00;
            idx_q   <= 3'd0;
            ones_q  <= 3'd0;
            start_q <= 1'b0;
            line_q  <= LINE_J;
            sent_q  <= 1'b0;
            half_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
            start_q <= start_d;
            line_q  <= line_d;
            sent_q  <= sent_d;
            half_q  <= half_d;
        end
    end

    assign dp_out     = line_q[1];
    assign dm_out     = line_q[0];
    assign byte_sent  = sent_q;
    assign eop_active = (state_q == ST_EOP_SE0) || (state_q == ST_EOP_J);

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder at CLKS_PER_BIT=8; cycle 0 is the cycle right after the load edge.
module tb_usb_tx_encoder;

    logic       clk;
    logic       n_rst;
    logic       load_enable;
    logic [7:0] parallel_in;
    logic       enable_timer;
    logic       eop_flag;
    logic       byte_sent;
    logic       dp_out;
    logic       dm_out;
    logic       eop_active;

    int checks = 0;
    int errors = 0;

    logic rec_dp   [0:127];
    logic rec_dm   [0:127];
    logic rec_eop  [0:127];
    logic rec_sent [0:127];

    usb_tx_encoder #(.CLKS_PER_BIT(8)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .load_enable  (load_enable),
        .parallel_in  (parallel_in),
        .enable_timer (enable_timer),
        .eop_flag     (eop_flag),
        .byte_sent    (byte_sent),
        .dp_out       (dp_out),
        .dm_out       (dm_out),
        .eop_active   (eop_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic record(input int c);
        rec_dp[c]   = dp_out;
        rec_dm[c]   = dm_out;
        rec_eop[c]  = eop_active;
        rec_sent[c] = byte_sent;
    endtask

    // Loads d, then records ncyc further cycles; optional enable_timer gap and one-cycle eop pulse.
    task automatic do_byte(input logic [7:0] d, input int ncyc, input int off_at,
                           input int off_len, input int eop_at);
        load_enable = 1'b1;
        parallel_in = d;
        @(posedge clk); #1;
        load_enable = 1'b0;
        record(0);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            record(c);
            if (c == off_at) enable_timer = 1'b0;
            if (c == off_at + off_len) enable_timer = 1'b1;
            eop_flag = (c == eop_at);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        load_enable = 1'b0;
        parallel_in = 8'h00;
        enable_timer = 1'b1;
        eop_flag = 1'b0;
        #12;
        checks++; if (dp_out !== 1'b1) begin errors++; $display("FAIL reset_dp got %b expected 1", dp_out); end
        checks++; if (dm_out !== 1'b0) begin errors++; $display("FAIL reset_dm got %b expected 0", dm_out); end
        checks++; if (byte_sent !== 1'b0) begin errors++; $display("FAIL reset_sent got %b expected 0", byte_sent); end
        checks++; if (eop_active !== 1'b0) begin errors++; $display("FAIL reset_eop got %b expected 0", eop_active); end
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({dp_out, dm_out, byte_sent} !== 3'b100) begin
            errors++; $display("FAIL idle_after_reset got %b expected 100", {dp_out, dm_out, byte_sent});
        end
    endtask

    task automatic test_zero_byte();
        logic tog, exp_t;
        do_byte(8'h00, 70, -1, 0, -1);
        for (int c = 1; c <= 70; c++) begin
            tog = rec_dp[c] ^ rec_dp[c-1];
            exp_t = (c <= 57) && (c % 8 == 1);
            checks++; if (tog !== exp_t) begin errors++; $display("FAIL zero_toggle cycle %0d got %b expected %b", c, tog, exp_t); end
            checks++; if (rec_sent[c] !== (c == 64)) begin errors++; $display("FAIL zero_sent cycle %0d got %b expected %b", c, rec_sent[c], c == 64); end
            checks++; if (rec_dm[c] !== ~rec_dp[c]) begin errors++; $display("FAIL zero_diff cycle %0d got dp=%b dm=%b", c, rec_dp[c], rec_dm[c]); end
        end
    endtask

    task automatic test_stuff_ff();
        logic tog, exp_t;
        do_byte(8'hFF, 80, -1, 0, -1);
        for (int c = 1; c <= 80; c++) begin
            tog = rec_dp[c] ^ rec_dp[c-1];
            exp_t = (c == 49);
            checks++; if (tog !== exp_t) begin errors++; $display("FAIL ff_toggle cycle %0d got %b expected %b", c, tog, exp_t); end
            checks++; if (rec_sent[c] !== (c == 72)) begin errors++; $display("FAIL ff_sent cycle %0d got %b expected %b", c, rec_sent[c], c == 72); end
        end
    endtask

    task automatic test_stuff_across_bytes();
        logic tog, exp_t;
        do_byte(8'hE0, 64, -1, 0, -1);
        for (int c = 1; c <= 64; c++) begin
            tog = rec_dp[c] ^ rec_dp[c-1];
            exp_t = (c inside {1, 9, 17, 25, 33});
            checks++; if (tog !== exp_t) begin errors++; $display("FAIL e0_toggle cycle %0d got %b expected %b", c, tog, exp_t); end
            checks++; if (rec_sent[c] !== (c == 64)) begin errors++; $display("FAIL e0_sent cycle %0d got %b expected %b", c, rec_sent[c], c == 64); end
        end
        do_byte(8'h07, 80, -1, 0, -1);
        for (int c = 1; c <= 80; c++) begin
            tog = rec_dp[c] ^ rec_dp[c-1];
            exp_t = (c inside {25, 33, 41, 49, 57, 65});
            checks++; if (tog !== exp_t) begin errors++; $display("FAIL 07_toggle cycle %0d got %b expected %b", c, tog, exp_t); end
            checks++; if (rec_sent[c] !== (c == 72)) begin errors++; $display("FAIL 07_sent cycle %0d got %b expected %b", c, rec_sent[c], c == 72); end
        end
    endtask

    task automatic test_timer_pause();
        logic tog, exp_t;
        do_byte(8'h55, 80, 20, 5, -1);
        for (int c = 1; c <= 80; c++) begin
            tog = rec_dp[c] ^ rec_dp[c-1];
            exp_t = (c inside {9, 30, 46, 62});
            checks++; if (tog !== exp_t) begin errors++; $display("FAIL pause_toggle cycle %0d got %b expected %b", c, tog, exp_t); end
            checks++; if (rec_sent[c] !== (c == 69)) begin errors++; $display("FAIL pause_sent cycle %0d got %b expected %b", c, rec_sent[c], c == 69); end
        end
    endtask

    task automatic test_back_to_back();
        logic tog, exp_t;
        do_byte(8'h00, 7, -1, 0, -1);
        checks++; if ((rec_dp[1] ^ rec_dp[0]) !== 1'b1) begin errors++; $display("FAIL b2b_first_toggle got 0 expected 1"); end
        // second load lands on the first byte's bit-0 boundary
        do_byte(8'h00, 70, -1, 0, -1);
        for (int c = 1; c <= 70; c++) begin
            tog = rec_dp[c] ^ rec_dp[c-1];
            exp_t = (c <= 57) && (c % 8 == 1);
            checks++; if (tog !== exp_t) begin errors++; $display("FAIL b2b_toggle cycle %0d got %b expected %b", c, tog, exp_t); end
            checks++; if (rec_sent[c] !== (c == 64)) begin errors++; $display("FAIL b2b_sent cycle %0d got %b expected %b", c, rec_sent[c], c == 64); end
        end
    endtask

    task automatic test_eop();
        logic [2:0] got, exp_v;
        do_byte(8'h00, 50, -1, 0, 20);
        for (int c = 0; c <= 50; c++) begin
            got = {rec_dp[c], rec_dm[c], rec_eop[c]};
            if (c < 21) exp_v = {~rec_dm[c], rec_dm[c], 1'b0};
            else if (c <= 36) exp_v = 3'b001;
            else if (c <= 44) exp_v = 3'b101;
            else exp_v = 3'b100;
            checks++; if (got !== exp_v) begin errors++; $display("FAIL eop_line cycle %0d got %b expected %b", c, got, exp_v); end
            checks++; if (rec_sent[c] !== 1'b0) begin errors++; $display("FAIL eop_sent cycle %0d got %b expected 0", c, rec_sent[c]); end
        end
        do_byte(8'h00, 70, -1, 0, -1);
        checks++; if ({rec_dp[0], rec_dm[0]} !== 2'b10) begin errors++; $display("FAIL post_eop_j got %b%b expected 10", rec_dp[0], rec_dm[0]); end
        checks++; if ({rec_dp[1], rec_dm[1]} !== 2'b01) begin errors++; $display("FAIL post_eop_k got %b%b expected 01", rec_dp[1], rec_dm[1]); end
        checks++; if (rec_sent[64] !== 1'b1) begin errors++; $display("FAIL post_eop_sent got %b expected 1", rec_sent[64]); end
        // eop_flag and load_enable together from idle
        load_enable = 1'b1;
        eop_flag = 1'b1;
        parallel_in = 8'h00;
        @(posedge clk); #1;
        load_enable = 1'b0;
        eop_flag = 1'b0;
        checks++; if ({dp_out, dm_out, eop_active} !== 3'b001) begin
            errors++; $display("FAIL eop_wins got %b expected 001", {dp_out, dm_out, eop_active});
        end
        repeat (24) @(posedge clk);
        #1;
        checks++; if ({dp_out, dm_out, eop_active} !== 3'b100) begin
            errors++; $display("FAIL eop_wins_exit got %b expected 100", {dp_out, dm_out, eop_active});
        end
        @(posedge clk); #1;
        checks++; if ({dp_out, byte_sent} !== 2'b10) begin
            errors++; $display("FAIL eop_wins_no_load got %b expected 10", {dp_out, byte_sent});
        end
    endtask

    task automatic test_reset_mid();
        do_byte(8'h00, 3, -1, 0, -1);
        checks++; if (rec_dp[3] !== 1'b0) begin errors++; $display("FAIL mid_pre_reset_dp got %b expected 0", rec_dp[3]); end
        #3 n_rst = 1'b0;
        #1;
        checks++; if ({dp_out, dm_out, byte_sent, eop_active} !== 4'b1000) begin
            errors++; $display("FAIL mid_reset_shift got %b expected 1000", {dp_out, dm_out, byte_sent, eop_active});
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        eop_flag = 1'b1;
        @(posedge clk); #1;
        eop_flag = 1'b0;
        checks++; if (eop_active !== 1'b1) begin errors++; $display("FAIL mid_eop_enter got %b expected 1", eop_active); end
        #3 n_rst = 1'b0;
        #1;
        checks++; if ({dp_out, dm_out, byte_sent, eop_active} !== 4'b1000) begin
            errors++; $display("FAIL mid_reset_eop got %b expected 1000", {dp_out, dm_out, byte_sent, eop_active});
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_zero_byte();
        test_stuff_ff();
        test_stuff_across_bytes();
        test_timer_pause();
        test_back_to_back();
        test_eop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
